// File: rtl/image_scheduler.sv
// Ping-pong image buffer scheduler: fills one bank from the host while the engine reads the other.
// Optional RUN watchdog enabled by defining IMAGE_SCHEDULER_TIMEOUT_EN.
module image_scheduler #(
  parameter int NUM_PIXELS     = 784,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        weights_ready,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        buf_we,
  output logic [10:0] buf_waddr,
  output logic [7:0]  buf_wdata,
  output logic        rd_bank,
  output logic        infer_start,
  input  logic        infer_busy,
  input  logic        infer_done,
  input  logic [3:0]  infer_digit,
  output logic        res_valid,
  output logic [3:0]  res_digit,
  input  logic        res_ready,
  output logic        err_timeout
);
  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;
  localparam logic [9:0] LAST_IDX = 10'(NUM_PIXELS - 1);

  state_t     state, state_nx;
  logic [9:0] wr_idx;
  logic       wr_bank;
  logic [1:0] full, set_full, clr_full;
  logic       xfer, last_xfer, oldest;
  logic       sel, fin_done, fin_to, ack, timeout_hit;
  logic       unused_busy;

  assign unused_busy = infer_busy;

  assign pix_ready   = ~full[wr_bank];
  assign xfer        = pix_valid & pix_ready;
  assign last_xfer   = xfer && (wr_idx == LAST_IDX);
  assign buf_we      = xfer;
  assign buf_waddr   = {wr_bank, wr_idx};
  assign buf_wdata   = pix_data;
  assign infer_start = (state == START);

  // With both banks full the writer points at the older one (it filled first).
  assign oldest   = (&full) ? wr_bank : full[1];
  assign set_full = {last_xfer & wr_bank, last_xfer & ~wr_bank};
  assign clr_full = {2{fin_done | fin_to}} & {rd_bank, ~rd_bank};

`ifdef IMAGE_SCHEDULER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == START) to_cnt <= '0;
    else if (state == RUN)     to_cnt <= to_cnt + TW'(1);
  end

  assign timeout_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst)         err_timeout <= 1'b0;
    else if (fin_to) err_timeout <= 1'b1;
  end
`else
  logic unused_to;
  assign unused_to   = (TIMEOUT_CYCLES > 0);
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    sel      = 1'b0;
    fin_done = 1'b0;
    fin_to   = 1'b0;
    ack      = 1'b0;
    case (state)
      IDLE:  if (weights_ready && |full) begin sel = 1'b1; state_nx = START; end
      START: state_nx = RUN;
      RUN: begin
        if (infer_done)       begin fin_done = 1'b1; state_nx = HOLD; end
        else if (timeout_hit) begin fin_to   = 1'b1; state_nx = HOLD; end
      end
      HOLD:  if (res_ready) begin ack = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      full      <= '0;
      rd_bank   <= 1'b0;
      res_valid <= 1'b0;
      res_digit <= '0;
    end else begin
      state <= state_nx;
      full  <= (full | set_full) & ~clr_full;
      if (xfer) begin
        wr_idx <= last_xfer ? '0 : wr_idx + 10'd1;
        if (last_xfer) wr_bank <= ~wr_bank;
      end
      if (sel) rd_bank <= oldest;
      if (fin_done) begin
        res_digit <= infer_digit;
        res_valid <= 1'b1;
      end
      if (fin_to) begin
        res_digit <= 4'hF;
        res_valid <= 1'b1;
      end
      if (ack) res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_image_scheduler.sv
// Randomized bench for image_scheduler with a queue-based behavioural model checked every cycle.
module tb_image_scheduler;
  localparam int NP = 784;
  localparam int TO = 16384;

  logic        clk = 1'b0;
  logic        rst, weights_ready, pix_valid, pix_ready, buf_we, rd_bank, infer_start;
  logic        infer_busy, infer_done, res_valid, res_ready, err_timeout;
  logic [7:0]  pix_data, buf_wdata;
  logic [10:0] buf_waddr;
  logic [3:0]  infer_digit, res_digit;

  always #5 clk = ~clk;

  image_scheduler #(.NUM_PIXELS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .weights_ready(weights_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .rd_bank(rd_bank), .infer_start(infer_start), .infer_busy(infer_busy),
    .infer_done(infer_done), .infer_digit(infer_digit),
    .res_valid(res_valid), .res_digit(res_digit), .res_ready(res_ready),
    .err_timeout(err_timeout)
  );

  int n_vec = 0, n_err = 0;

  // Model: full banks in completion order; the head is the one being served.
  int       full_q[$];
  int       m_wr_idx = 0;
  bit       m_wr_bank = 0, m_rd_bank = 0, m_res_valid = 0, m_err = 0;
  logic [3:0] m_res_digit = 0;
  int       m_phase = 0;        // 0 waiting, 1 start pulse, 2 engine running, 3 result offered
  longint   mc = 0, run_at = 0;

  // Stimulus controls
  bit rst_req, spur, eng_never, wr_var;
  int vmode, rr_mode, pix_left, eng_cnt, dly_min, dly_max, fix_digit, n_start;

  function automatic bit m_full(bit b);
    foreach (full_q[i]) if (full_q[i] == int'(b)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    bit xfer;
    mc++;
    if (rst) begin
      full_q.delete();
      m_wr_idx = 0; m_wr_bank = 0; m_rd_bank = 0; m_res_valid = 0;
      m_res_digit = 0; m_err = 0; m_phase = 0;
      return;
    end
    xfer = pix_valid && !m_full(m_wr_bank);
    case (m_phase)
      0: if (weights_ready && full_q.size() > 0) begin m_rd_bank = (full_q[0] != 0); m_phase = 1; end
      1: begin m_phase = 2; run_at = mc; end
      2: begin
        if (infer_done) begin
          m_res_digit = infer_digit; m_res_valid = 1; void'(full_q.pop_front()); m_phase = 3;
        end
`ifdef IMAGE_SCHEDULER_TIMEOUT_EN
        else if (mc - run_at == TO) begin
          m_err = 1; m_res_digit = 4'hF; m_res_valid = 1; void'(full_q.pop_front()); m_phase = 3;
        end
`endif
      end
      default: if (res_ready) begin m_res_valid = 0; m_phase = 0; end
    endcase
    if (xfer) begin
      if (m_wr_idx == NP - 1) begin
        full_q.push_back(int'(m_wr_bank)); m_wr_idx = 0; m_wr_bank = !m_wr_bank;
      end else m_wr_idx++;
    end
  endtask

  task automatic compare();
    bit rdy;
    rdy = !m_full(m_wr_bank);
    chk("pix_ready", pix_ready, rdy);
    chk("buf_we", buf_we, pix_valid && rdy);
    if (pix_valid && rdy) begin
      chk("buf_waddr", buf_waddr, {m_wr_bank, 10'(m_wr_idx)});
      chk("buf_wdata", buf_wdata, pix_data);
    end
    chk("rd_bank", rd_bank, m_rd_bank);
    chk("infer_start", infer_start, m_phase == 1);
    chk("res_valid", res_valid, m_res_valid);
    chk("res_digit", res_digit, m_res_digit);
    chk("err_timeout", err_timeout, m_err);
  endtask

  task automatic step();
    bit took;
    took = pix_valid && pix_ready && !rst;
    @(posedge clk);
    model_edge();
    #1;
    if (took && pix_left > 0) pix_left--;
    rst           = rst_req;
    pix_valid     = (pix_left > 0) && (vmode == 1 || (vmode == 2 && $urandom_range(0, 1) == 1));
    pix_data      = 8'($urandom);
    weights_ready = wr_var;
    res_ready     = (rr_mode == 1) || (rr_mode == 2 && $urandom_range(0, 3) == 0);
    infer_done    = 1'b0;
    infer_busy    = eng_cnt > 0;
    if (rst_req) eng_cnt = 0;
    else if (infer_start) begin
      n_start++;
      if (!eng_never) eng_cnt = $urandom_range(dly_min, dly_max);
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        infer_done  = 1'b1;
        infer_digit = (fix_digit >= 0) ? 4'(fix_digit) : 4'($urandom);
      end
    end else if (spur && $urandom_range(0, 15) == 0) begin
      infer_done  = 1'b1;
      infer_digit = 4'($urandom);
    end
    @(negedge clk);
    compare();
  endtask

  function automatic bit cond(int which);
    case (which)
      0: return infer_start === 1'b1;
      1: return res_valid === 1'b1;
      default: return err_timeout === 1'b1;
    endcase
  endfunction

  task automatic wait_for(string nm, int which, int bound);
    int k = 0;
    while (!cond(which) && k < bound) begin step(); k++; end
    chk(nm, cond(which), 1);
  endtask

  task automatic do_reset();
    pix_left = 0; vmode = 0; rst_req = 1;
    step(); step();
    rst_req = 0;
    step();
  endtask

  initial begin
    int s0, k;
    rst = 1; pix_valid = 0; pix_data = 0; weights_ready = 0; res_ready = 0;
    infer_done = 0; infer_digit = 0; infer_busy = 0;
    rst_req = 1; spur = 0; eng_never = 0; wr_var = 0;
    vmode = 0; rr_mode = 0; pix_left = 0; eng_cnt = 0;
    dly_min = 1; dly_max = 1; fix_digit = -1; n_start = 0;

    do_reset();
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_err", err_timeout, 0);

    // One full image, fixed digit 7, latency of first start.
    wr_var = 1; fix_digit = 7; dly_min = 20; dly_max = 20;
    s0 = n_start; pix_left = NP; vmode = 1;
    k = 0;
    while (pix_left > 1 && k < 2000) begin step(); k++; end
    chk("last_waddr", buf_waddr, 11'd783);
    chk("last_we", buf_we, 1);
    step();
    chk("lat_t1", infer_start, 0);
    step();
    chk("lat_t2", infer_start, 1);
    chk("first_bank", rd_bank, 0);
    wait_for("res1_wait", 1, 100);
    chk("res1_digit", res_digit, 7);
    chk("one_start", n_start - s0, 1);

    // Back-to-back two images with a slow engine.
    do_reset();
    rr_mode = 1; fix_digit = -1; dly_min = 8000; dly_max = 8000;
    pix_left = 2 * NP + 1; vmode = 1;
    wait_for("bb_start1", 0, 1000);
    chk("bb_bank1", rd_bank, 0);
    dly_min = 5; dly_max = 5;
    repeat (900) step();
    chk("bb_blocked", pix_ready, 0);
    chk("bb_left", pix_left, 1);
    wait_for("bb_res1", 1, 8000);
    wait_for("bb_start2", 0, 50);
    chk("bb_bank2", rd_bank, 1);

    // Result held while the consumer stalls.
    rr_mode = 0; pix_left = 2 * NP; vmode = 1;
    wait_for("hold_res", 1, 200);
    s0 = n_start;
    repeat (50) begin
      step();
      chk("hold_valid", res_valid, 1);
      chk("hold_nostart", infer_start, 0);
    end
    chk("hold_starts", n_start - s0, 0);
    rr_mode = 1;

    // Weights not ready with both banks full.
    do_reset();
    wr_var = 0; s0 = n_start; pix_left = 2 * NP; vmode = 1;
    repeat (1700) step();
    chk("nw_blocked", pix_ready, 0);
    chk("nw_starts", n_start - s0, 0);
    wr_var = 1;
    step();
    chk("nw_t0", infer_start, 0);
    step();
    chk("nw_t1", infer_start, 1);
    chk("nw_bank", rd_bank, 0);
    repeat (40) step();

    // Reset mid-fill, then mid-run.
    do_reset();
    pix_left = NP; vmode = 1; k = 0;
    while (pix_left > NP - 400 && k < 1000) begin step(); k++; end
    do_reset();
    chk("rf_ready", pix_ready, 1);
    chk("rf_valid", res_valid, 0);
    pix_left = 1; vmode = 1;
    step();
    chk("rf_we", buf_we, 1);
    chk("rf_addr", buf_waddr, 0);
    do_reset();
    dly_min = 1000; dly_max = 1000; pix_left = NP; vmode = 1;
    wait_for("rr_start", 0, 1000);
    repeat (5) step();
    do_reset();
    s0 = n_start;
    chk("rr_start0", infer_start, 0);
    chk("rr_valid", res_valid, 0);
    chk("rr_bank", rd_bank, 0);
    pix_left = 1; vmode = 1;
    step();
    chk("rr_we", buf_we, 1);
    chk("rr_addr", buf_waddr, 0);
    repeat (10) step();
    chk("rr_nostart", n_start - s0, 0);

    // Randomized traffic, including stray done pulses.
    do_reset();
    spur = 1; dly_min = 1; dly_max = 40; vmode = 2; rr_mode = 2; pix_left = 1000000;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) wr_var = ($urandom_range(0, 3) != 0);
      step();
    end
    spur = 0; pix_left = 0; wr_var = 1; rr_mode = 1;

`ifdef IMAGE_SCHEDULER_TIMEOUT_EN
    do_reset();
    eng_never = 1; rr_mode = 0; pix_left = NP; vmode = 1;
    wait_for("to_flag", 2, TO + 2000);
    chk("to_digit", res_digit, 4'hF);
    chk("to_valid", res_valid, 1);
    eng_never = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/image_scheduler.md
IMAGE_SCHEDULER -- requirements
Module: image_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default 784, giving pixels per image.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16384, giving the maximum cycles from start to done.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 weights_ready  input  1  high once weights/biases are loaded.
REQ-006 pix_valid  input  1  pixel byte present from host loader.
REQ-007 pix_data  input  8  signed preprocessed pixel.
REQ-008 pix_ready  output  1  scheduler accepts pixel this cycle.
REQ-009 buf_we  output  1  image RAM write enable.
REQ-010 buf_waddr  output  11  image RAM write address, {bank, index[9:0]}.
REQ-011 buf_wdata  output  8  image RAM write data, equal to pix_data.
REQ-012 rd_bank  output  1  bank the engine reads; MSB of engine pixel address.
REQ-013 infer_start  output  1  single-cycle start pulse to engine.
REQ-014 infer_busy  input  1  engine busy.
REQ-015 infer_done  input  1  engine single-cycle done pulse.
REQ-016 infer_digit  input  4  engine predicted digit.
REQ-017 res_valid  output  1  result available.
REQ-018 res_digit  output  4  result digit.
REQ-019 res_ready  input  1  consumer accepts result.
REQ-020 err_timeout  output  1  sticky timeout flag.

Function
REQ-021 The block SHALL keep two image banks (ping-pong); fill side and read side SHALL never be the same bank while an inference runs.
REQ-022 Handshake: a pixel transfers when pix_valid and pix_ready are both high; buf_we SHALL equal that product combinationally, with buf_waddr = {wr_bank, wr_idx}.
REQ-023 wr_idx SHALL increment per transfer; on the transfer at NUM_PIXELS-1 it SHALL wrap to 0, mark wr_bank full, and toggle wr_bank.
REQ-024 pix_ready SHALL be high only when the bank at wr_bank is not full.
REQ-025 Control FSM states: IDLE, START, RUN, HOLD.
REQ-026 IDLE: when weights_ready is high and a full bank exists, rd_bank SHALL be set to the oldest full bank and the FSM SHALL go to START.
REQ-027 START: infer_start SHALL pulse for exactly one cycle, the timeout counter SHALL clear, and the FSM SHALL go to RUN.
REQ-028 RUN: on infer_done, the FSM SHALL latch infer_digit into res_digit, clear the full flag of rd_bank, assert res_valid, and go to HOLD.
REQ-029 HOLD: the FSM SHALL stay in HOLD while res_valid is high and res_ready is low; on res_ready it SHALL drop res_valid and return to IDLE the next cycle.
REQ-030 If a pixel transfer completes a bank in the same cycle that IDLE selects a bank, the newly completed bank SHALL be served on the next pass, never twice and never skipped.
REQ-031 If weights_ready is low in IDLE, the FSM SHALL not start; pixel filling continues until both banks are full.
REQ-032 An infer_done pulse outside RUN SHALL be ignored.
REQ-033 Latency: the first infer_start SHALL occur 2 cycles after the accepted final pixel of a bank, provided the FSM is in IDLE and weights_ready is high.

Reset
REQ-034 On rst, the block SHALL clear wr_idx, wr_bank, rd_bank, both full flags, res_digit, res_valid, infer_start, err_timeout, and the timeout counter, and SHALL enter IDLE.
REQ-035 A rst asserted mid-inference SHALL discard the in-flight image and result; the engine is reset from the same rst.

Configuration
REQ-036 With macro IMAGE_SCHEDULER_TIMEOUT_EN defined, a RUN counter SHALL run; when it reaches TIMEOUT_CYCLES without infer_done, the block SHALL set err_timeout, load res_digit=4'hF, set res_valid, clear the rd_bank full flag, and go to HOLD.
REQ-037 Without IMAGE_SCHEDULER_TIMEOUT_EN, no counter SHALL exist, err_timeout SHALL be tied 0, and RUN SHALL wait indefinitely.

Verification
REQ-038 Stream 784 pixels with weights_ready=1 -> buf_waddr 0..783 in bank 0, infer_start pulses once with rd_bank=0, model done with digit 7 -> res_valid=1, res_digit=7.
REQ-039 Stream 1568 pixels back to back with slow done (8000 cycles) -> bank 1 fills during RUN, pix_ready=0 on pixel 1569, and the second start uses rd_bank=1.
REQ-040 Hold res_ready=0 for 50 cycles -> res_valid and res_digit stable and no new infer_start.
REQ-041 weights_ready=0 with both banks full -> no infer_start; raise weights_ready -> start on bank 0 after 1 cycle.
REQ-042 TIMEOUT_EN defined, done never asserted -> after 16384 cycles err_timeout=1 and res_digit=4'hF.
REQ-043 rst asserted at pixel 400 and during RUN -> all outputs return to reset values, and the next image writes from address 0 of bank 0.
